tlb_refill_walker: RTL

//  - Services TLB misses: fetches the page-table entry (PTE) for the missing VPN and picks a victim TLB slot.
//  - Writes back the victim's D/R bits to the page table when needed, then refills the slot.
//  - Sits between the fully-associative TLB (upstream, raises the miss) and the page-table RAM in main memory.
//  - Reports either refill-done with the PPN, or page fault.
//  - PTE/TLB entry format: [31]=V, [30]=D, [29]=R, [PPN_W-1:0]=PPN, all other bits zero.

---
 rtl/tlb_refill_walker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tlb_refill_walker.sv
// TLB miss walker: fetches the PTE for a missing VPN, picks a victim slot,
// writes back a dirty/referenced victim, then refills the slot or reports a fault.
module tlb_refill_walker #(
  parameter int VPN_W       = 6,
  parameter int PPN_W       = 2,
  parameter int TLB_ENTRIES = 4,
  parameter int IDX_W       = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [VPN_W-1:0]       req_vpn,
  input  logic                   req_write,
  output logic                   req_ready,
  output logic                   pt_rd_en,
  output logic [VPN_W-1:0]       pt_rd_addr,
  input  logic                   pt_rd_valid,
  input  logic [31:0]            pt_rd_data,
  output logic                   pt_wr_en,
  output logic [VPN_W-1:0]       pt_wr_addr,
  output logic [31:0]            pt_wr_data,
  input  logic                   pt_wr_ack,
  input  logic [TLB_ENTRIES-1:0] tlb_valid_vec,
  output logic [IDX_W-1:0]       victim_idx,
  input  logic [VPN_W-1:0]       victim_tag,
  input  logic [31:0]            victim_entry,
  output logic                   tlb_wr_en,
  output logic [VPN_W-1:0]       tlb_wr_tag,
  output logic [31:0]            tlb_wr_entry,
  output logic                   done,
  output logic [PPN_W-1:0]       done_ppn,
  output logic                   fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WB, S_FILL, S_FAULT
  } state_t;

  state_t state, state_d;

  logic [VPN_W-1:0] vpn_q;
  logic             write_q;
  logic             pte_v_q;
  logic [PPN_W-1:0] pte_ppn_q;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] victim_idx_q;
  logic             used_rr_q;
  logic [VPN_W-1:0] pt_rd_addr_q;
  logic [VPN_W-1:0] pt_wr_addr_q;
  logic [31:0]      pt_wr_data_q;
  logic [VPN_W-1:0] tlb_wr_tag_q;
  logic [31:0]      tlb_wr_entry_q;
  logic [PPN_W-1:0] done_ppn_q;

  logic [IDX_W-1:0] victim_sel;
  logic             sel_from_rr;
  logic             wb_needed;
  logic             fill_load;
  logic [31:0]      fill_entry;
  logic             unused_pte_bits;

  assign unused_pte_bits = ^pt_rd_data[30:PPN_W];

  // Lowest invalid slot wins; the descending scan leaves the smallest index last.
  always_comb begin
    victim_sel  = rr_ptr;
    sel_from_rr = 1'b1;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!tlb_valid_vec[i]) begin
        victim_sel  = IDX_W'(i);
        sel_from_rr = 1'b0;
      end
    end
  end

  assign wb_needed  = tlb_valid_vec[victim_sel] & victim_entry[31] &
                      (victim_entry[30] | victim_entry[29]);
  assign fill_entry = {1'b1, write_q, 1'b1, {(29 - PPN_W){1'b0}}, pte_ppn_q};
  assign fill_load  = ((state == S_CHECK) && pte_v_q && !wb_needed) ||
                      ((state == S_WB) && pt_wr_ack);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (req_valid) state_d = S_RD_REQ;
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: if (pt_rd_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (!pte_v_q)       state_d = S_FAULT;
        else if (wb_needed) state_d = S_WB;
        else                state_d = S_FILL;
      end
      S_WB:      if (pt_wr_ack) state_d = S_FILL;
      S_FILL:    state_d = S_IDLE;
      S_FAULT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign pt_rd_en  = (state == S_RD_REQ);
  assign pt_wr_en  = (state == S_WB);
  assign tlb_wr_en = (state == S_FILL);
  assign done      = (state == S_FILL);
  assign fault     = (state == S_FAULT);

  // The TLB answers victim_tag/entry combinationally, so CHECK must present the live choice.
  assign victim_idx   = (state == S_CHECK) ? victim_sel : victim_idx_q;
  assign pt_rd_addr   = pt_rd_addr_q;
  assign pt_wr_addr   = pt_wr_addr_q;
  assign pt_wr_data   = pt_wr_data_q;
  assign tlb_wr_tag   = tlb_wr_tag_q;
  assign tlb_wr_entry = tlb_wr_entry_q;
  assign done_ppn     = done_ppn_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      vpn_q          <= '0;
      write_q        <= 1'b0;
      pte_v_q        <= 1'b0;
      pte_ppn_q      <= '0;
      rr_ptr         <= '0;
      victim_idx_q   <= '0;
      used_rr_q      <= 1'b0;
      pt_rd_addr_q   <= '0;
      pt_wr_addr_q   <= '0;
      pt_wr_data_q   <= '0;
      tlb_wr_tag_q   <= '0;
      tlb_wr_entry_q <= '0;
      done_ppn_q     <= '0;
    end else begin
      state <= state_d;
      if ((state == S_IDLE) && req_valid) begin
        vpn_q        <= req_vpn;
        write_q      <= req_write;
        pt_rd_addr_q <= req_vpn;
      end
      if ((state == S_RD_WAIT) && pt_rd_valid) begin
        pte_v_q   <= pt_rd_data[31];
        pte_ppn_q <= pt_rd_data[PPN_W-1:0];
      end
      // A faulting walk leaves the victim bookkeeping alone.
      if ((state == S_CHECK) && pte_v_q) begin
        victim_idx_q <= victim_sel;
        used_rr_q    <= sel_from_rr;
        if (wb_needed) begin
          pt_wr_addr_q <= victim_tag;
          pt_wr_data_q <= victim_entry;
        end
      end
      if (fill_load) begin
        tlb_wr_tag_q   <= vpn_q;
        tlb_wr_entry_q <= fill_entry;
        done_ppn_q     <= pte_ppn_q;
      end
      if ((state == S_FILL) && used_rr_q) rr_ptr <= rr_ptr + 1'b1;
    end
  end

endmodule
